// File: rtl/usb_bus_power_ctrl.sv
// Device-side USB bus/power state controller: tracks reset/suspend/resume from the
// line-state monitor, sequences PHY SuspendM and device-initiated remote wakeup (timed K).
module usb_bus_power_ctrl #(
  parameter int CLK_FREQ_MHZ    = 60,
  parameter int WAKE_IDLE_US    = 5000,
  parameter int WAKE_DRIVE_US   = 2000,
  parameter int WAKE_TIMEOUT_US = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] line_state,
  input  logic       reset_detect,
  input  logic       suspend_detect,
  input  logic       resume_detect,
  input  logic       remote_wakeup_en,
  input  logic       remote_wakeup_req,
  output logic [2:0] bus_state,
  output logic       bus_reset,
  output logic       reset_done,
  output logic       resume_done,
  output logic       wake_fail,
  output logic       suspended,
  output logic       phy_suspendm,
  output logic       drive_k
);

  localparam int WAKE_IDLE_CYC    = CLK_FREQ_MHZ * WAKE_IDLE_US;
  localparam int WAKE_DRIVE_CYC   = CLK_FREQ_MHZ * WAKE_DRIVE_US;
  localparam int WAKE_TIMEOUT_CYC = CLK_FREQ_MHZ * WAKE_TIMEOUT_US;

  if (WAKE_IDLE_CYC >= 2**24 || WAKE_DRIVE_CYC >= 2**24 || WAKE_TIMEOUT_CYC >= 2**24 ||
      WAKE_DRIVE_CYC < 1 || WAKE_TIMEOUT_CYC < 1) begin : g_bad_params
    $error("usb_bus_power_ctrl: cycle counts must lie in 1 .. 2^24-1");
  end

  localparam logic [23:0] IDLE_MIN     = 24'(WAKE_IDLE_CYC);
  localparam logic [23:0] DRIVE_LAST   = 24'(WAKE_DRIVE_CYC - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(WAKE_TIMEOUT_CYC - 1);
  localparam logic [1:0]  LS_J         = 2'b01;

  typedef enum logic [2:0] {
    ST_POWERED    = 3'd0,
    ST_IN_RESET   = 3'd1,
    ST_ACTIVE     = 3'd2,
    ST_SUSPENDED  = 3'd3,
    ST_RESUMING   = 3'd4,
    ST_WAKE_DRIVE = 3'd5,
    ST_WAKE_WAIT  = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic        wake_pending_q, wake_pending_d;
  logic        reset_det_prev_q, suspend_det_prev_q;
  logic        bus_reset_q, bus_reset_d;
  logic        reset_done_q, reset_done_d;
  logic        resume_done_q, resume_done_d;
  logic        wake_fail_q, wake_fail_d;
  logic        suspended_q, suspended_d;
  logic        phy_suspendm_q, phy_suspendm_d;
  logic        drive_k_q, drive_k_d;
  logic        reset_rise, suspend_rise;

  assign reset_rise   = reset_detect & ~reset_det_prev_q;
  assign suspend_rise = suspend_detect & ~suspend_det_prev_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    wake_pending_d = wake_pending_q;
    bus_reset_d    = 1'b0;
    reset_done_d   = 1'b0;
    resume_done_d  = 1'b0;
    wake_fail_d    = 1'b0;

    if (reset_rise) begin
      state_d        = ST_IN_RESET;
      bus_reset_d    = 1'b1;
      wake_pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_POWERED: ;
        ST_IN_RESET: begin
          if (!reset_detect) begin
            state_d      = ST_ACTIVE;
            reset_done_d = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (suspend_rise) state_d = ST_SUSPENDED;
        end
        ST_SUSPENDED: begin
          if (!remote_wakeup_en)      wake_pending_d = 1'b0;
          else if (remote_wakeup_req) wake_pending_d = 1'b1;
          // Host resume wins over our own pending wakeup in the same cycle.
          if (resume_detect)                              state_d = ST_RESUMING;
          else if (wake_pending_q && timer_q >= IDLE_MIN) state_d = ST_WAKE_DRIVE;
        end
        ST_RESUMING: begin
          if (line_state == LS_J) begin
            state_d       = ST_ACTIVE;
            resume_done_d = 1'b1;
          end
        end
        ST_WAKE_DRIVE: begin
          // The monitor sees our own K here, so resume_detect and line_state are ignored.
          wake_pending_d = 1'b0;
          if (timer_q == DRIVE_LAST) state_d = ST_WAKE_WAIT;
        end
        ST_WAKE_WAIT: begin
          if (line_state == LS_J) begin
            state_d       = ST_ACTIVE;
            resume_done_d = 1'b1;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d     = ST_SUSPENDED;
            wake_fail_d = 1'b1;
          end
        end
        default: state_d = ST_POWERED;
      endcase
    end

    if (reset_rise || state_d != state_q) timer_d = '0;
    else if (timer_q == '1)               timer_d = timer_q;
    else                                  timer_d = timer_q + 24'd1;

    suspended_d    = (state_d == ST_SUSPENDED);
    phy_suspendm_d = (state_d != ST_SUSPENDED);
    drive_k_d      = (state_d == ST_WAKE_DRIVE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_POWERED;
      timer_q            <= '0;
      wake_pending_q     <= 1'b0;
      reset_det_prev_q   <= 1'b0;
      suspend_det_prev_q <= 1'b0;
      bus_reset_q        <= 1'b0;
      reset_done_q       <= 1'b0;
      resume_done_q      <= 1'b0;
      wake_fail_q        <= 1'b0;
      suspended_q        <= 1'b0;
      phy_suspendm_q     <= 1'b1;
      drive_k_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      timer_q            <= timer_d;
      wake_pending_q     <= wake_pending_d;
      reset_det_prev_q   <= reset_detect;
      suspend_det_prev_q <= suspend_detect;
      bus_reset_q        <= bus_reset_d;
      reset_done_q       <= reset_done_d;
      resume_done_q      <= resume_done_d;
      wake_fail_q        <= wake_fail_d;
      suspended_q        <= suspended_d;
      phy_suspendm_q     <= phy_suspendm_d;
      drive_k_q          <= drive_k_d;
    end
  end

  assign bus_state    = state_q;
  assign bus_reset    = bus_reset_q;
  assign reset_done   = reset_done_q;
  assign resume_done  = resume_done_q;
  assign wake_fail    = wake_fail_q;
  assign suspended    = suspended_q;
  assign phy_suspendm = phy_suspendm_q;
  assign drive_k      = drive_k_q;

endmodule

// File: tb/tb_usb_bus_power_ctrl.sv
// Self-checking bench for usb_bus_power_ctrl: vector table, directed wakeup/reset sequences,
// then randomized stimulus compared each cycle against a behavioural model.
module tb_usb_bus_power_ctrl;

  localparam int IDLE    = 10;
  localparam int DRIVE   = 5;
  localparam int TIMEOUT = 20;

  localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10, SE1 = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] line_state = J;
  logic       reset_detect = 1'b0, suspend_detect = 1'b0, resume_detect = 1'b0;
  logic       remote_wakeup_en = 1'b0, remote_wakeup_req = 1'b0;
  logic [2:0] bus_state;
  logic       bus_reset, reset_done, resume_done, wake_fail, suspended, phy_suspendm, drive_k;

  int n_checks = 0;
  int n_errors = 0;
  bit model_chk = 1'b0;

  usb_bus_power_ctrl #(
    .CLK_FREQ_MHZ(1), .WAKE_IDLE_US(IDLE), .WAKE_DRIVE_US(DRIVE), .WAKE_TIMEOUT_US(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .line_state(line_state), .reset_detect(reset_detect),
    .suspend_detect(suspend_detect), .resume_detect(resume_detect),
    .remote_wakeup_en(remote_wakeup_en), .remote_wakeup_req(remote_wakeup_req),
    .bus_state(bus_state), .bus_reset(bus_reset), .reset_done(reset_done),
    .resume_done(resume_done), .wake_fail(wake_fail), .suspended(suspended),
    .phy_suspendm(phy_suspendm), .drive_k(drive_k)
  );

  always #5 clk = ~clk;

  // Behavioural model: bus state as a plain integer plus "cycles spent in this state".
  int m_state = 0, m_age = 0;
  bit m_pend = 0, m_prev_rd = 0, m_prev_sd = 0;
  bit m_br = 0, m_rdn = 0, m_rsd = 0, m_wf = 0;

  task automatic model_edge();
    int  nxt;
    bit  rd_rise, sd_rise, old_pend;
    m_br = 0; m_rdn = 0; m_rsd = 0; m_wf = 0;
    if (rst) begin
      m_state = 0; m_age = 0; m_pend = 0; m_prev_rd = 0; m_prev_sd = 0;
      return;
    end
    rd_rise  = reset_detect && !m_prev_rd;
    sd_rise  = suspend_detect && !m_prev_sd;
    old_pend = m_pend;
    nxt      = m_state;
    if (rd_rise) begin
      nxt = 1; m_br = 1; m_pend = 0;
    end else if (m_state == 1) begin
      if (!reset_detect) begin nxt = 2; m_rdn = 1; end
    end else if (m_state == 2) begin
      if (sd_rise) nxt = 3;
    end else if (m_state == 3) begin
      m_pend = remote_wakeup_en ? (m_pend | remote_wakeup_req) : 1'b0;
      if (resume_detect)                nxt = 4;
      else if (old_pend && m_age >= IDLE) nxt = 5;
    end else if (m_state == 4) begin
      if (line_state == J) begin nxt = 2; m_rsd = 1; end
    end else if (m_state == 5) begin
      m_pend = 0;
      if (m_age + 1 == DRIVE) nxt = 6;
    end else if (m_state == 6) begin
      if (line_state == J)           begin nxt = 2; m_rsd = 1; end
      else if (m_age + 1 == TIMEOUT) begin nxt = 3; m_wf = 1; end
    end
    m_age     = (rd_rise || nxt != m_state) ? 0 : m_age + 1;
    m_state   = nxt;
    m_prev_rd = reset_detect;
    m_prev_sd = suspend_detect;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {bus_reset, reset_done, resume_done, wake_fail, suspended, phy_suspendm, drive_k};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    if (model_chk) begin
      check("model_state", 32'(bus_state), 32'(m_state));
      check("model_outs", 32'(dut_outs()),
            32'({m_br, m_rdn, m_rsd, m_wf, m_state == 3, m_state != 3, m_state == 5}));
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name,
                            output int waited);
    waited = 0;
    while (bus_state != s && waited < budget) begin
      tick();
      waited++;
    end
    n_checks++;
    if (bus_state != s) begin
      n_errors++;
      $display("FAIL %s: state %0d after %0d cycles, wanted %0d", name, bus_state, waited, s);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] line;
    logic       rd, sd, resd;
    logic [2:0] st;
    logic [6:0] outs;   // {bus_reset, reset_done, resume_done, wake_fail, suspended, phy_suspendm, drive_k}
  } vec_t;

  vec_t vecs[18];

  initial begin
    int n, dk_cycles, bad_state, dk_seen;

    vecs[0]  = '{1'b1, J,   1'b0, 1'b0, 1'b0, 3'd0, 7'b0000010};
    vecs[1]  = '{1'b0, J,   1'b0, 1'b0, 1'b0, 3'd0, 7'b0000010};
    vecs[2]  = '{1'b0, J,   1'b0, 1'b1, 1'b0, 3'd0, 7'b0000010};  // suspend ignored in POWERED
    vecs[3]  = '{1'b0, K,   1'b0, 1'b0, 1'b1, 3'd0, 7'b0000010};  // resume ignored in POWERED
    vecs[4]  = '{1'b0, SE0, 1'b1, 1'b0, 1'b0, 3'd1, 7'b1000010};
    vecs[5]  = '{1'b0, SE0, 1'b1, 1'b0, 1'b0, 3'd1, 7'b0000010};
    vecs[6]  = '{1'b0, SE0, 1'b1, 1'b0, 1'b0, 3'd1, 7'b0000010};
    vecs[7]  = '{1'b0, SE0, 1'b1, 1'b0, 1'b0, 3'd1, 7'b0000010};
    vecs[8]  = '{1'b0, J,   1'b0, 1'b0, 1'b0, 3'd2, 7'b0100010};
    vecs[9]  = '{1'b0, J,   1'b0, 1'b0, 1'b0, 3'd2, 7'b0000010};
    vecs[10] = '{1'b0, J,   1'b0, 1'b1, 1'b0, 3'd3, 7'b0000100};
    vecs[11] = '{1'b0, J,   1'b0, 1'b1, 1'b0, 3'd3, 7'b0000100};
    vecs[12] = '{1'b0, K,   1'b0, 1'b0, 1'b1, 3'd4, 7'b0000010};
    vecs[13] = '{1'b0, K,   1'b0, 1'b0, 1'b0, 3'd4, 7'b0000010};
    vecs[14] = '{1'b0, SE0, 1'b0, 1'b0, 1'b0, 3'd4, 7'b0000010};  // low-speed EOP tolerated
    vecs[15] = '{1'b0, J,   1'b0, 1'b0, 1'b0, 3'd2, 7'b0010010};
    vecs[16] = '{1'b0, J,   1'b0, 1'b0, 1'b0, 3'd2, 7'b0000010};
    vecs[17] = '{1'b0, J,   1'b0, 1'b0, 1'b0, 3'd2, 7'b0000010};

    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst; line_state = vecs[i].line;
      reset_detect = vecs[i].rd; suspend_detect = vecs[i].sd; resume_detect = vecs[i].resd;
      tick();
      check($sformatf("vec%0d_state", i), 32'(bus_state), 32'(vecs[i].st));
      check($sformatf("vec%0d_outs", i), 32'(dut_outs()), 32'(vecs[i].outs));
    end
    resume_detect = 1'b0;
    model_chk = 1'b1;

    // Remote wakeup answered by host J three cycles into WAKE_WAIT.
    remote_wakeup_en = 1'b1; suspend_detect = 1'b1;
    tick();
    check("wk_suspend_entry", 32'(bus_state), 32'd3);
    tick(); tick();
    remote_wakeup_req = 1'b1;
    wait_state(3'd5, 40, "wk_reach_drive", n);
    // Timer reads 0 on the entry cycle, so the move happens on the edge after it reads IDLE.
    check("wk_edges_to_drive", 32'(n + 2), 32'(IDLE + 1));
    line_state = K;
    dk_cycles = 0;
    for (int i = 0; i < 20 && drive_k; i++) begin
      dk_cycles++;
      tick();
    end
    check("wk_drive_k_width", 32'(dk_cycles), 32'(DRIVE));
    check("wk_wait_state", 32'(bus_state), 32'd6);
    tick(); tick();
    line_state = J;
    tick();
    check("wk_active", 32'(bus_state), 32'd2);
    check("wk_resume_done", 32'(resume_done), 32'd1);
    tick();
    check("wk_resume_done_pulse", 32'(resume_done), 32'd0);

    // Remote wakeup with the line stuck at K: times out back to SUSPENDED.
    suspend_detect = 1'b0; tick();
    suspend_detect = 1'b1; tick();
    wait_state(3'd5, 40, "wf_reach_drive", n);
    line_state = K;
    wait_state(3'd6, 20, "wf_reach_wait", n);
    n = 0;
    while (!wake_fail && n < 40) begin
      tick();
      n++;
    end
    check("wf_cycles_to_fail", 32'(n), 32'(TIMEOUT));
    check("wf_state", 32'(bus_state), 32'd3);
    check("wf_suspendm", 32'(phy_suspendm), 32'd0);
    check("wf_suspended", 32'(suspended), 32'd1);
    tick();
    check("wf_pulse_width", 32'(wake_fail), 32'd0);

    // Request without the host-granted feature is ignored.
    remote_wakeup_en = 1'b0;
    bad_state = 0; dk_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus_state != 3'd3) bad_state++;
      if (drive_k) dk_seen++;
    end
    check("noen_state_leaves", 32'(bad_state), 32'd0);
    check("noen_drive_k", 32'(dk_seen), 32'd0);

    // Bus reset two cycles into WAKE_DRIVE.
    remote_wakeup_en = 1'b1;
    wait_state(3'd5, 40, "rd_reach_drive", n);
    tick(); tick();
    reset_detect = 1'b1;
    tick();
    check("rd_drive_k", 32'(drive_k), 32'd0);
    check("rd_bus_reset", 32'(bus_reset), 32'd1);
    check("rd_state", 32'(bus_state), 32'd1);
    reset_detect = 1'b0; remote_wakeup_req = 1'b0;
    tick();
    check("rd_reset_done", 32'(reset_done), 32'd1);

    // Synchronous rst while SUSPENDED.
    suspend_detect = 1'b0; tick();
    suspend_detect = 1'b1; tick();
    check("rst_pre_state", 32'(bus_state), 32'd3);
    rst = 1'b1;
    tick();
    check("rst_state", 32'(bus_state), 32'd0);
    check("rst_outs", 32'(dut_outs()), 32'b0000010);
    rst = 1'b0; suspend_detect = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst = ($urandom_range(0, 599) == 0);
      if (reset_detect) reset_detect = ($urandom_range(0, 3) != 0);
      else              reset_detect = ($urandom_range(0, 89) == 0);
      if ($urandom_range(0, 15) == 0) suspend_detect = ~suspend_detect;
      resume_detect = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) remote_wakeup_en = ~remote_wakeup_en;
      if ($urandom_range(0, 9) == 0)  remote_wakeup_req = ~remote_wakeup_req;
      r = $urandom_range(0, 9);
      if ((i / 500) % 2 == 0) line_state = (r < 5) ? J : (r < 8) ? K : (r == 8) ? SE0 : SE1;
      else                    line_state = (r < 1) ? J : (r < 8) ? K : (r == 8) ? SE0 : SE1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
